// File: rtl/or1200_checker_ctrl.sv
// Supervisory controller for the OR1200 privilege checker: warm-up arming, violation
// filtering, halt-request handshake with ack timeout, and sticky alarm until clear.
module or1200_checker_ctrl #(
   parameter int unsigned ARM_CYCLES  = 16,
   parameter int unsigned THRESH      = 2,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chk_en,
   input  logic             immu_fault_ok,
   input  logic             dmmu_fault_ok,
   input  logic             supv_consistent,
   input  logic             halt_ack,
   input  logic             clr,
   output logic             halt_req,
   output logic             alarm,
   output logic             armed,
   output logic             timeout,
   output logic [2:0]       viol_src,
   output logic [CNT_W-1:0] viol_cnt
);

   // Counters fire on the cycle whose increment lands on LIMIT-1; limits of 0 or 1 mean one cycle.
   localparam int unsigned ARM_TRIG  = (ARM_CYCLES > 1) ? ARM_CYCLES - 2 : 0;
   localparam int unsigned ARM_W     = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES + 1) : 1;
   localparam int unsigned WAIT_TRIG = (ACK_TIMEOUT > 1) ? ACK_TIMEOUT - 2 : 0;
   localparam int unsigned WAIT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam int unsigned THR_EFF   = (THRESH == 0) ? 1 : THRESH;
   localparam int unsigned CONS_W    = $clog2(THR_EFF + 1);

   typedef enum logic [2:0] {
      S_DISARM   = 3'd0,
      S_ARMING   = 3'd1,
      S_MONITOR  = 3'd2,
      S_HALT_REQ = 3'd3,
      S_LOCKED   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
   logic [CONS_W-1:0]   consec_q, consec_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                halt_req_q, halt_req_d;
   logic                alarm_q, alarm_d;
   logic                armed_q, armed_d;
   logic                timeout_q, timeout_d;
   logic [2:0]          viol_src_q, viol_src_d;
   logic [CNT_W-1:0]    viol_cnt_q, viol_cnt_d;

   logic [2:0] viol_bits_c;
   logic       viol_c;

   assign viol_bits_c = {~supv_consistent, ~dmmu_fault_ok, ~immu_fault_ok};
   assign viol_c      = |viol_bits_c;

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      arm_cnt_d  = arm_cnt_q;
      consec_d   = consec_q;
      wait_d     = wait_q;
      halt_req_d = halt_req_q;
      alarm_d    = alarm_q;
      timeout_d  = timeout_q;
      viol_src_d = viol_src_q;
      viol_cnt_d = viol_cnt_q;

      if (viol_c && (state_q == S_MONITOR || state_q == S_HALT_REQ || state_q == S_LOCKED)
          && (viol_cnt_q != '1)) begin
         viol_cnt_d = viol_cnt_q + CNT_W'(1);
      end

      case (state_q)
         S_DISARM: begin
            if (chk_en) begin
               state_d   = S_ARMING;
               arm_cnt_d = '0;
            end
         end
         S_ARMING: begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
            if (!chk_en) begin
               state_d = S_DISARM;
            end else if (arm_cnt_q == ARM_W'(ARM_TRIG)) begin
               state_d  = S_MONITOR;
               consec_d = '0;
            end
         end
         S_MONITOR: begin
            if (viol_c && (consec_q == CONS_W'(THR_EFF - 1))) begin
               // Trigger has priority over a simultaneous disarm
               state_d    = S_HALT_REQ;
               consec_d   = '0;
               wait_d     = '0;
               viol_src_d = viol_bits_c;
               alarm_d    = 1'b1;
               halt_req_d = 1'b1;
            end else begin
               consec_d = viol_c ? consec_q + CONS_W'(1) : '0;
               if (!chk_en) begin
                  state_d  = S_DISARM;
                  consec_d = '0;
               end
            end
         end
         S_HALT_REQ: begin
            wait_d = wait_q + WAIT_W'(1);
            if (halt_ack) begin
               state_d    = S_LOCKED;
               halt_req_d = 1'b0;
            end else if (wait_q == WAIT_W'(WAIT_TRIG)) begin
               // Fail-safe: keep requesting halt after the CPU never answered
               state_d   = S_LOCKED;
               timeout_d = 1'b1;
            end
         end
         S_LOCKED: begin
            if (clr) begin
               state_d    = S_DISARM;
               alarm_d    = 1'b0;
               timeout_d  = 1'b0;
               viol_src_d = '0;
               halt_req_d = 1'b0;
               consec_d   = '0;
            end
         end
         default: begin
            state_d = S_DISARM;
         end
      endcase

      armed_d = (state_d == S_MONITOR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_DISARM;
         arm_cnt_q  <= '0;
         consec_q   <= '0;
         wait_q     <= '0;
         halt_req_q <= 1'b0;
         alarm_q    <= 1'b0;
         armed_q    <= 1'b0;
         timeout_q  <= 1'b0;
         viol_src_q <= '0;
         viol_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         arm_cnt_q  <= arm_cnt_d;
         consec_q   <= consec_d;
         wait_q     <= wait_d;
         halt_req_q <= halt_req_d;
         alarm_q    <= alarm_d;
         armed_q    <= armed_d;
         timeout_q  <= timeout_d;
         viol_src_q <= viol_src_d;
         viol_cnt_q <= viol_cnt_d;
      end
   end

   assign halt_req = halt_req_q;
   assign alarm    = alarm_q;
   assign armed    = armed_q;
   assign timeout  = timeout_q;
   assign viol_src = viol_src_q;
   assign viol_cnt = viol_cnt_q;

endmodule

// File: tb/tb_or1200_checker_ctrl.sv
// Bench for or1200_checker_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the supervisory rules.
module tb_or1200_checker_ctrl;

   localparam int ARM = 16;
   localparam int THR = 2;
   localparam int CW  = 8;
   localparam int TO  = 64;
   localparam int CNT_MAX = (1 << CW) - 1;

   localparam int P_OFF = 0, P_WARM = 1, P_WATCH = 2, P_WAIT = 3, P_HOLD = 4;

   logic clk = 1'b0;
   logic rst, chk_en, immu_fault_ok, dmmu_fault_ok, supv_consistent, halt_ack, clr;
   logic halt_req, alarm, armed, timeout;
   logic [2:0]    viol_src;
   logic [CW-1:0] viol_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   int         m_phase, m_age, m_run, m_wait, m_cnt;
   logic       m_halt, m_alarm, m_to;
   logic [2:0] m_src;

   or1200_checker_ctrl #(
      .ARM_CYCLES (ARM),
      .THRESH     (THR),
      .CNT_W      (CW),
      .ACK_TIMEOUT(TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .chk_en         (chk_en),
      .immu_fault_ok  (immu_fault_ok),
      .dmmu_fault_ok  (dmmu_fault_ok),
      .supv_consistent(supv_consistent),
      .halt_ack       (halt_ack),
      .clr            (clr),
      .halt_req       (halt_req),
      .alarm          (alarm),
      .armed          (armed),
      .timeout        (timeout),
      .viol_src       (viol_src),
      .viol_cnt       (viol_cnt)
   );

   always #5 clk = ~clk;

   // Reference: phases with elapsed-cycle counts, applied once per clock edge
   function automatic void model_step();
      logic [2:0] vb;
      logic       v;
      vb = {!supv_consistent, !dmmu_fault_ok, !immu_fault_ok};
      v  = |vb;
      if (rst) begin
         m_phase = P_OFF; m_age = 0; m_run = 0; m_wait = 0; m_cnt = 0;
         m_halt = 1'b0; m_alarm = 1'b0; m_to = 1'b0; m_src = 3'b000;
         return;
      end
      if (m_phase >= P_WATCH && v && m_cnt < CNT_MAX) m_cnt++;
      case (m_phase)
         P_OFF: if (chk_en) begin m_phase = P_WARM; m_age = 0; end
         P_WARM: begin
            if (!chk_en) m_phase = P_OFF;
            else begin
               m_age++;
               if (m_age >= ((ARM > 1) ? ARM - 1 : 1)) begin m_phase = P_WATCH; m_run = 0; end
            end
         end
         P_WATCH: begin
            if (v) m_run++;
            else   m_run = 0;
            if (v && m_run >= THR) begin
               m_phase = P_WAIT; m_wait = 0; m_run = 0;
               m_halt = 1'b1; m_alarm = 1'b1; m_src = vb;
            end else if (!chk_en) begin
               m_phase = P_OFF; m_run = 0;
            end
         end
         P_WAIT: begin
            if (halt_ack) begin
               m_phase = P_HOLD; m_halt = 1'b0;
            end else begin
               m_wait++;
               if (m_wait >= ((TO > 1) ? TO - 1 : 1)) begin m_phase = P_HOLD; m_to = 1'b1; end
            end
         end
         P_HOLD: begin
            if (clr) begin
               m_phase = P_OFF; m_run = 0;
               m_halt = 1'b0; m_alarm = 1'b0; m_to = 1'b0; m_src = 3'b000;
            end
         end
         default: m_phase = P_OFF;
      endcase
   endfunction

   function automatic logic [14:0] exp_vec();
      return {m_halt, m_alarm, m_phase == P_WATCH, m_to, m_src, 8'(m_cnt)};
   endfunction

   function automatic logic [14:0] dut_vec();
      return {halt_req, alarm, armed, timeout, viol_src, viol_cnt};
   endfunction

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rst = 1'b0; chk_en = 1'b0; immu_fault_ok = 1'b1; dmmu_fault_ok = 1'b1;
      supv_consistent = 1'b1; halt_ack = 1'b0; clr = 1'b0;
   endtask

   task automatic arm_up();
      set_idle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk_en = 1'b1;
      repeat (ARM) cycle();
   endtask

   task automatic test_reset();
      set_idle();
      chk_en = 1'b1; immu_fault_ok = 1'b0; rst = 1'b1;
      cycle();
      cycle();
      n_chk++;
      if (dut_vec() !== 15'h0) $display("FAIL reset_outputs got %h want %h", dut_vec(), 15'h0);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_arming();
      set_idle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk_en = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         cycle();
         n_chk++;
         if (armed !== (i >= ARM)) $display("FAIL arm_timing cycle %0d got %b want %b", i, armed, i >= ARM);
         else n_pass++;
      end
      n_chk++;
      if ({halt_req, alarm, viol_cnt} !== 10'h0) $display("FAIL arm_quiet got %h want 0", {halt_req, alarm, viol_cnt});
      else n_pass++;
   endtask

   task automatic test_isolated_viol();
      arm_up();
      repeat (5) begin
         dmmu_fault_ok = 1'b0;
         cycle();
         dmmu_fault_ok = 1'b1;
         cycle();
      end
      n_chk++;
      if (dut_vec() !== {4'b0010, 3'b000, 8'd5}) $display("FAIL isolated_viol got %h want %h", dut_vec(), {4'b0010, 3'b000, 8'd5});
      else n_pass++;
   endtask

   task automatic test_trigger_ack_clr();
      arm_up();
      supv_consistent = 1'b0; immu_fault_ok = 1'b0;
      cycle();
      n_chk++;
      if (halt_req !== 1'b0) $display("FAIL trig_early got %b want 0", halt_req);
      else n_pass++;
      cycle();
      n_chk++;
      if ({halt_req, alarm, viol_src} !== 5'b11101) $display("FAIL trig_raise got %b want 11101", {halt_req, alarm, viol_src});
      else n_pass++;
      supv_consistent = 1'b1; immu_fault_ok = 1'b1; halt_ack = 1'b1;
      cycle();
      halt_ack = 1'b0;
      n_chk++;
      if (dut_vec() !== {4'b0100, 3'b101, 8'd2}) $display("FAIL ack_locked got %h want %h", dut_vec(), {4'b0100, 3'b101, 8'd2});
      else n_pass++;
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      n_chk++;
      if (dut_vec() !== {4'b0000, 3'b000, 8'd2}) $display("FAIL clr_clear got %h want %h", dut_vec(), {4'b0000, 3'b000, 8'd2});
      else n_pass++;
   endtask

   task automatic test_timeout();
      arm_up();
      dmmu_fault_ok = 1'b0;
      repeat (2) cycle();
      dmmu_fault_ok = 1'b1;
      clr = 1'b1;
      for (int i = 1; i <= 70; i++) begin
         if (i == 4) clr = 1'b0;
         cycle();
         n_chk++;
         if ({halt_req, timeout} !== {1'b1, i >= TO - 1})
            $display("FAIL timeout_wait cycle %0d got %b want %b", i, {halt_req, timeout}, {1'b1, i >= TO - 1});
         else n_pass++;
      end
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      n_chk++;
      if ({halt_req, alarm, timeout, viol_src} !== 6'h0) $display("FAIL timeout_clr got %b want 0", {halt_req, alarm, timeout, viol_src});
      else n_pass++;
   endtask

   task automatic test_ack_at_timeout();
      arm_up();
      immu_fault_ok = 1'b0;
      repeat (2) cycle();
      immu_fault_ok = 1'b1;
      repeat (TO - 2) cycle();
      halt_ack = 1'b1;
      cycle();
      halt_ack = 1'b0;
      n_chk++;
      if (dut_vec() !== {4'b0100, 3'b001, 8'd2}) $display("FAIL ack_wins got %h want %h", dut_vec(), {4'b0100, 3'b001, 8'd2});
      else n_pass++;
   endtask

   task automatic test_trigger_vs_disarm();
      arm_up();
      dmmu_fault_ok = 1'b0;
      cycle();
      chk_en = 1'b0;
      cycle();
      dmmu_fault_ok = 1'b1;
      n_chk++;
      if ({halt_req, alarm, armed, viol_src} !== 6'b110010) $display("FAIL trig_over_disarm got %b want 110010", {halt_req, alarm, armed, viol_src});
      else n_pass++;
   endtask

   task automatic test_saturate_and_reset();
      arm_up();
      supv_consistent = 1'b0;
      repeat (300) cycle();
      supv_consistent = 1'b1;
      n_chk++;
      if (dut_vec() !== {4'b1101, 3'b100, 8'd255}) $display("FAIL saturate got %h want %h", dut_vec(), {4'b1101, 3'b100, 8'd255});
      else n_pass++;
      arm_up();
      immu_fault_ok = 1'b0;
      repeat (5) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      immu_fault_ok = 1'b1;
      n_chk++;
      if (dut_vec() !== 15'h0) $display("FAIL reset_mid_halt got %h want 0", dut_vec());
      else n_pass++;
   endtask

   task automatic test_arming_drop();
      set_idle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         dmmu_fault_ok = i[0];
         supv_consistent = i[1];
         cycle();
      end
      chk_en = 1'b0;
      dmmu_fault_ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         n_chk++;
         if (dut_vec() !== 15'h0) $display("FAIL arming_drop cycle %0d got %h want 0", i, dut_vec());
         else n_pass++;
      end
      dmmu_fault_ok = 1'b1;
   endtask

   task automatic test_random();
      set_idle();
      rst = 1'b1;
      cycle();
      for (int i = 0; i < 3000; i++) begin
         rst             = ($urandom_range(0, 299) == 0);
         chk_en          = ($urandom_range(0, 19) != 0);
         immu_fault_ok   = ($urandom_range(0, 7) != 0);
         dmmu_fault_ok   = ($urandom_range(0, 7) != 0);
         supv_consistent = ($urandom_range(0, 7) != 0);
         halt_ack        = ($urandom_range(0, 24) == 0);
         clr             = ($urandom_range(0, 14) == 0);
         cycle();
         n_chk++;
         if (dut_vec() !== exp_vec()) $display("FAIL random cycle %0d got %h want %h", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      model_step();
      test_reset();
      test_arming();
      test_isolated_viol();
      test_trigger_ack_clr();
      test_timeout();
      test_ack_at_timeout();
      test_trigger_vs_disarm();
      test_saturate_and_reset();
      test_arming_drop();
      test_random();
      n_chk++;
      if (dut_vec() !== exp_vec()) $display("FAIL final_model got %h want %h", dut_vec(), exp_vec());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
